// File: rtl/i2c_pkg.sv
// Shared I2C slave definitions: bus idle level, filter defaults, edge record
// and the slave ASM state encoding.
package i2c_pkg;

  localparam logic I2C_IDLE_LVL        = 1'b1;
  localparam int   I2C_FILT_CYCLES_DEF = 4;
  localparam int   I2C_FILT_CNT_W_DEF  = 4;

  typedef enum logic [2:0] {
    ASM_IDLE      = 3'd0,
    ASM_ADDR      = 3'd1,
    ASM_ADDR_ACK  = 3'd2,
    ASM_WR_DATA   = 3'd3,
    ASM_RD_DATA   = 3'd4,
    ASM_DATA_ACK  = 3'd5,
    ASM_WAIT_STOP = 3'd6
  } i2c_asm_state_e;

  typedef struct packed {
    logic pe;
    logic ne;
  } i2c_edge_t;

  function automatic i2c_edge_t i2c_edges(input logic cur, input logic prev);
    i2c_edge_t e;
    e.pe = cur & ~prev;
    e.ne = ~cur & prev;
    return e;
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Single-line conditioner: two-flop synchronizer followed by a stability
// counter that only lets the filtered level follow after FILT_CYCLES agreeing samples.
module i2c_line_filter
  import i2c_pkg::*;
#(
  parameter int FILT_CYCLES = I2C_FILT_CYCLES_DEF,
  parameter int CNT_W       = I2C_FILT_CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic line_filt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             filt_q;
  logic             filt_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, keeping the two sync stages distinct.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= I2C_IDLE_LVL;
      sync_q2 <= I2C_IDLE_LVL;
    end else begin
      sync_q1 <= line_in;
      sync_q2 <= sync_q1;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync_q2 != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync_q2;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      filt_q <= I2C_IDLE_LVL;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign line_filt = filt_q;

endmodule

// File: rtl/i2c_slave_edge_filter.sv
// I2C slave front end: filtered SCL/SDA levels, edge strobes and START/STOP strobes.
// Optional bus_busy output is built when I2C_EDGE_FILTER_BUSY_EN is defined.
module i2c_slave_edge_filter
  import i2c_pkg::*;
#(
  parameter int FILT_CYCLES = I2C_FILT_CYCLES_DEF,
  parameter int CNT_W       = I2C_FILT_CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic fscl,
  output logic fsda,
  output logic cpe,
  output logic cne,
  output logic dpe,
  output logic dne,
  output logic start,
  output logic stop
`ifdef I2C_EDGE_FILTER_BUSY_EN
  ,
  output logic bus_busy
`endif
);

  localparam int              WARM_CYCLES = FILT_CYCLES + 3;
  localparam int              WU_W        = $clog2(WARM_CYCLES + 1);
  localparam logic [WU_W-1:0] WU_LAST     = WU_W'(WARM_CYCLES);

  logic            fscl_d;
  logic            fsda_d;
  logic [WU_W-1:0] wu_cnt;
  logic            warm_done;
  i2c_edge_t       scl_e;
  i2c_edge_t       sda_e;

  i2c_line_filter #(
    .FILT_CYCLES(FILT_CYCLES),
    .CNT_W      (CNT_W)
  ) u_scl_filter (
    .clk      (clk),
    .reset    (reset),
    .line_in  (scl_in),
    .line_filt(fscl)
  );

  i2c_line_filter #(
    .FILT_CYCLES(FILT_CYCLES),
    .CNT_W      (CNT_W)
  ) u_sda_filter (
    .clk      (clk),
    .reset    (reset),
    .line_in  (sda_in),
    .line_filt(fsda)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fscl_d <= I2C_IDLE_LVL;
      fsda_d <= I2C_IDLE_LVL;
    end else begin
      fscl_d <= fscl;
      fsda_d <= fsda;
    end
  end

  // Strobes stay masked until the reset-time pipeline contents have flushed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wu_cnt <= '0;
    end else if (wu_cnt != WU_LAST) begin
      wu_cnt <= wu_cnt + WU_W'(1);
    end
  end

  assign warm_done = (wu_cnt == WU_LAST);

  assign scl_e = i2c_edges(fscl, fscl_d);
  assign sda_e = i2c_edges(fsda, fsda_d);

  assign cpe   = warm_done & scl_e.pe;
  assign cne   = warm_done & scl_e.ne;
  assign dpe   = warm_done & sda_e.pe;
  assign dne   = warm_done & sda_e.ne;
  // SCL high on both sides of the SDA edge; a coincident SCL change disqualifies it.
  assign start = dne & fscl & fscl_d;
  assign stop  = dpe & fscl & fscl_d;

`ifdef I2C_EDGE_FILTER_BUSY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_busy <= 1'b0;
    end else if (start) begin
      bus_busy <= 1'b1;
    end else if (stop) begin
      bus_busy <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_i2c_slave_edge_filter.sv
// Self-checking bench for i2c_slave_edge_filter: vector table, hand-written
// corner sequences and random stimulus against a sliding-window reference model.
module tb_i2c_slave_edge_filter;

  localparam int F = 4;

`ifdef I2C_EDGE_FILTER_BUSY_EN
  localparam bit BUSY_EN = 1'b1;
`else
  localparam bit BUSY_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic scl_in = 1'b1;
  logic sda_in = 1'b1;
  logic fscl, fsda, cpe, cne, dpe, dne, start, stop;
  logic busy_obs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

`ifdef I2C_EDGE_FILTER_BUSY_EN
  logic bus_busy;
  assign busy_obs = bus_busy;
`else
  assign busy_obs = 1'b0;
`endif

  i2c_slave_edge_filter #(
    .FILT_CYCLES(F),
    .CNT_W      (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .scl_in(scl_in),
    .sda_in(sda_in),
    .fscl  (fscl),
    .fsda  (fsda),
    .cpe   (cpe),
    .cne   (cne),
    .dpe   (dpe),
    .dne   (dne),
    .start (start),
    .stop  (stop)
`ifdef I2C_EDGE_FILTER_BUSY_EN
    ,
    .bus_busy(bus_busy)
`endif
  );

  // ---------------- reference model ----------------
  // Raw levels seen at each edge; the filter acts on the sample two edges old.
  // The filtered level flips once the last F such samples all disagree with it.
  bit       m_raw_scl[$];
  bit       m_raw_sda[$];
  bit       m_smp_scl[$];
  bit       m_smp_sda[$];
  bit       m_fscl, m_fsda, m_busy, m_start_prev, m_stop_prev;
  int       m_edges;
  bit [8:0] m_exp;

  function automatic bit synced(input bit raw[$]);
    return (raw.size() >= 3) ? raw[raw.size() - 3] : 1'b1;
  endfunction

  function automatic bit filt_update(input bit cur, input bit smp[$]);
    if (smp.size() < F) return cur;
    foreach (smp[i]) if (smp[i] == cur) return cur;
    return ~cur;
  endfunction

  task automatic model_reset();
    m_raw_scl.delete();
    m_raw_sda.delete();
    m_smp_scl.delete();
    m_smp_sda.delete();
    m_fscl = 1'b1;
    m_fsda = 1'b1;
    m_busy = 1'b0;
    m_start_prev = 1'b0;
    m_stop_prev  = 1'b0;
    m_edges = 0;
  endtask

  task automatic model_edge();
    bit nscl, nsda, en, cr, cf, dr, df, st, sp;
    m_edges++;
    if (m_start_prev) m_busy = 1'b1;
    else if (m_stop_prev) m_busy = 1'b0;
    m_raw_scl.push_back(scl_in);
    m_raw_sda.push_back(sda_in);
    if (m_raw_scl.size() > 3) void'(m_raw_scl.pop_front());
    if (m_raw_sda.size() > 3) void'(m_raw_sda.pop_front());
    m_smp_scl.push_back(synced(m_raw_scl));
    m_smp_sda.push_back(synced(m_raw_sda));
    if (m_smp_scl.size() > F) void'(m_smp_scl.pop_front());
    if (m_smp_sda.size() > F) void'(m_smp_sda.pop_front());
    nscl = filt_update(m_fscl, m_smp_scl);
    nsda = filt_update(m_fsda, m_smp_sda);
    en = (m_edges >= F + 3);
    cr = en & nscl & ~m_fscl;
    cf = en & ~nscl & m_fscl;
    dr = en & nsda & ~m_fsda;
    df = en & ~nsda & m_fsda;
    st = df & nscl & m_fscl;
    sp = dr & nscl & m_fscl;
    m_fscl = nscl;
    m_fsda = nsda;
    m_start_prev = st;
    m_stop_prev  = sp;
    m_exp = {nscl, nsda, cr, cf, dr, df, st, sp, m_busy & BUSY_EN};
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [8:0] obs_vec();
    return {fscl, fsda, cpe, cne, dpe, dne, start, stop, busy_obs};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check("model", int'(obs_vec()), int'(m_exp));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit scl;
    bit sda;
    int hold;
    bit e_fscl;
    bit e_fsda;
    int e_cedges;
    int e_dedges;
    int e_start;
    int e_stop;
    bit e_busy;
  } vec_t;

  vec_t vecs[18];

  initial begin
    vecs[0]  = '{1, 1, 10, 1, 1, 0, 0, 0, 0, 0};  // idle
    vecs[1]  = '{0, 1, 3,  1, 1, 0, 0, 0, 0, 0};  // 3-cycle SCL glitch ...
    vecs[2]  = '{1, 1, 8,  1, 1, 0, 0, 0, 0, 0};  // ... rejected
    vecs[3]  = '{1, 0, 8,  1, 0, 0, 1, 1, 0, 1};  // START
    vecs[4]  = '{1, 1, 8,  1, 1, 0, 1, 0, 1, 0};  // STOP
    vecs[5]  = '{1, 0, 3,  1, 1, 0, 0, 0, 0, 0};  // counter restart: low 3
    vecs[6]  = '{1, 1, 1,  1, 1, 0, 0, 0, 0, 0};  //   high 1
    vecs[7]  = '{1, 0, 4,  1, 1, 0, 0, 0, 0, 0};  //   low 4 (still in pipeline)
    vecs[8]  = '{1, 0, 6,  1, 0, 0, 1, 1, 0, 1};  //   fsda falls, one START
    vecs[9]  = '{1, 1, 8,  1, 1, 0, 1, 0, 1, 0};  // STOP
    vecs[10] = '{1, 0, 8,  1, 0, 0, 1, 1, 0, 1};  // START
    vecs[11] = '{0, 0, 8,  0, 0, 1, 0, 0, 0, 1};  // SCL low
    vecs[12] = '{0, 1, 8,  0, 1, 0, 1, 0, 0, 1};  // SDA rises with SCL low
    vecs[13] = '{1, 1, 8,  1, 1, 1, 0, 0, 0, 1};  // SCL high
    vecs[14] = '{0, 0, 8,  0, 0, 1, 1, 0, 0, 1};  // simultaneous fall
    vecs[15] = '{1, 1, 8,  1, 1, 1, 1, 0, 0, 1};  // simultaneous rise, no STOP
    vecs[16] = '{1, 0, 8,  1, 0, 0, 1, 1, 0, 1};  // repeated START
    vecs[17] = '{1, 1, 8,  1, 1, 0, 1, 0, 1, 0};  // STOP
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", int'(obs_vec()), 32'h180);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) step();

    for (int i = 0; i < 18; i++) begin
      int nce, nde, nst, nsp;
      nce = 0;
      nde = 0;
      nst = 0;
      nsp = 0;
      scl_in = vecs[i].scl;
      sda_in = vecs[i].sda;
      for (int c = 0; c < vecs[i].hold; c++) begin
        step();
        nce += int'(cpe) + int'(cne);
        nde += int'(dpe) + int'(dne);
        nst += int'(start);
        nsp += int'(stop);
      end
      check($sformatf("vec%0d_fscl", i), int'(fscl), int'(vecs[i].e_fscl));
      check($sformatf("vec%0d_fsda", i), int'(fsda), int'(vecs[i].e_fsda));
      check($sformatf("vec%0d_scl_edges", i), nce, vecs[i].e_cedges);
      check($sformatf("vec%0d_sda_edges", i), nde, vecs[i].e_dedges);
      check($sformatf("vec%0d_start", i), nst, vecs[i].e_start);
      check($sformatf("vec%0d_stop", i), nsp, vecs[i].e_stop);
`ifdef I2C_EDGE_FILTER_BUSY_EN
      check($sformatf("vec%0d_busy", i), int'(bus_busy), int'(vecs[i].e_busy));
`endif
    end

    // Latency: fscl falls on edge F+2 after the first low sample.
    scl_in = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      check($sformatf("lat_fscl_e%0d", e), int'(fscl), int'(e < F + 2));
      check($sformatf("lat_cne_e%0d", e), int'(cne), int'(e == F + 2));
      check($sformatf("lat_ss_e%0d", e), int'({start, stop}), 0);
    end
    scl_in = 1'b1;
    repeat (10) step();

    // Reset mid-transfer with both lines held low.
    sda_in = 1'b0;
    repeat (8) step();
    scl_in = 1'b0;
    repeat (8) step();
    check("pre_reset_levels", int'({fscl, fsda}), 0);
    #3;
    reset = 1'b1;
    #1;
    check("mid_reset_idle", int'(obs_vec()), 32'h180);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    begin
      int nst;
      nst = 0;
      for (int e = 1; e <= 10; e++) begin
        step();
        nst += int'(start);
        check($sformatf("rst_strobes_e%0d", e), int'({cpe, cne, dpe, dne, start, stop}), 0);
        if (e >= F + 1) begin
          check($sformatf("rst_levels_e%0d", e), int'({fscl, fsda}), (e >= F + 2) ? 0 : 3);
        end
      end
      check("rst_no_start", nst, 0);
    end
    scl_in = 1'b1;
    sda_in = 1'b1;
    repeat (10) step();

    // Randomized levels and hold lengths, checked cycle by cycle against the model.
    for (int s = 0; s < 80; s++) begin
      int hold;
      scl_in = 1'($urandom_range(0, 1));
      sda_in = 1'($urandom_range(0, 1));
      hold = int'($urandom_range(1, 8));
      for (int c = 0; c < hold; c++) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
